map_block_decoder: RTL



---
 rtl/map_block_decoder_pkg.sv | 40 ++++
 rtl/map_block_decoder_acs.sv | 24 ++
 rtl/map_block_decoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/map_block_decoder_pkg.sv
// Trellis helpers, FSM state type and saturating metric arithmetic for map_block_decoder.
package map_block_decoder_pkg;

  typedef enum logic {
    FWD = 1'b0,
    BWD = 1'b1
  } fsm_t;

  // Largest metric magnitude of a w-bit signed metric; NEG is its negation.
  function automatic int metric_lim(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int metric_neg(input int unsigned w);
    return -metric_lim(w);
  endfunction

  function automatic int sat_add(input int a, input int b, input int lim);
    int s;
    s = a + b;
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

  // Only bit 0 of the current state affects the successor and the parity.
  function automatic logic [1:0] next_state(input logic s0, input logic u);
    return {s0, u};
  endfunction

  function automatic logic parity(input logic s0, input logic u);
    return u ^ s0;
  endfunction

  // Bipolar correlation of the branch labels with the received pair.
  function automatic int branch_metric(input int ys, input int yp, input logic u, input logic p);
    return (u ? ys : -ys) + (p ? yp : -yp);
  endfunction

endpackage

// File: rtl/map_block_decoder_acs.sv
// Two-way saturating add-compare-select; ties keep the m0/g0 branch.
module map_acs
  import map_block_decoder_pkg::*;
#(
  parameter int unsigned W_M = 6
) (
  input  logic signed [W_M-1:0] m0,
  input  logic signed [W_M-1:0] g0,
  input  logic signed [W_M-1:0] m1,
  input  logic signed [W_M-1:0] g1,
  output logic signed [W_M-1:0] metric_c
);

  localparam int LIM = metric_lim(W_M);

  int s0, s1;

  always_comb begin
    s0 = sat_add(int'(m0), int'(g0), LIM);
    s1 = sat_add(int'(m1), int'(g1), LIM);
    metric_c = (s1 > s0) ? W_M'(s1) : W_M'(s0);
  end

endmodule

// File: rtl/map_block_decoder.sv
// Block max-log-MAP decoder for the 4-state rate-1/2 recursive trellis.
// MAP_BLOCK_DECODER_TERMINATED_EN: block ends in state 0 (beta_N = {0,NEG,NEG,NEG}).
module map_block_decoder
  import map_block_decoder_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned W_IN = 3,
  parameter int unsigned W_M  = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [W_IN-1:0] in_ys,
  input  logic signed [W_IN-1:0] in_yp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [W_M:0]    out_llr,
  output logic                   out_bit,
  output logic [$clog2(N)-1:0]   out_idx,
  output logic                   out_last
);

  typedef logic signed [W_M-1:0] metric_t;

  localparam int unsigned TW     = $clog2(N);
  localparam int          LIM    = metric_lim(W_M);
  localparam metric_t     NEG_M  = W_M'(metric_neg(W_M));
  localparam logic [TW-1:0] T_LAST = TW'(N - 1);

`ifdef MAP_BLOCK_DECODER_TERMINATED_EN
  localparam metric_t BETA_TAIL = NEG_M;
`else
  localparam metric_t BETA_TAIL = W_M'(0);
`endif

  fsm_t fsm_q, fsm_d;

  metric_t alpha_q [4];
  metric_t beta_q  [4];
  metric_t acs_a   [4];
  metric_t acs_b   [4];
  metric_t alpha_n [4];
  metric_t beta_n  [4];
  metric_t gin     [2][2];
  metric_t gbw     [2][2];

  logic signed [W_IN-1:0] ys_buf [N];
  logic signed [W_IN-1:0] yp_buf [N];
  metric_t                alpha_buf [N][4];

  logic [TW-1:0] t_q;
  logic          load_q;
  logic          done_q;
  logic          in_fire_c;
  logic          out_fire_c;
  logic          step_c;
  logic signed [W_M:0] llr_c;
  int            l0, l1, v;

  assign in_fire_c  = in_valid & in_ready;
  assign out_fire_c = out_valid & out_ready;
  assign step_c     = (fsm_q == BWD) & ~load_q & ~done_q & (~out_valid | out_ready);

  // Branch metrics indexed [s0][u]: live input for alpha, buffered symbol for beta/LLR.
  always_comb begin
    for (int s0 = 0; s0 < 2; s0++) begin
      for (int u = 0; u < 2; u++) begin
        gin[s0][u] = W_M'(branch_metric(int'(in_ys), int'(in_yp), 1'(u),
                                        parity(1'(s0), 1'(u))));
        gbw[s0][u] = W_M'(branch_metric(int'(ys_buf[t_q]), int'(yp_buf[t_q]), 1'(u),
                                        parity(1'(s0), 1'(u))));
      end
    end
  end

  // Alpha: predecessors of s' are {0,s'[1]} and {1,s'[1]}; both share one branch label.
  // Beta: successors of s are {s[0],0} and {s[0],1}.
  for (genvar g = 0; g < 4; g++) begin : g_acs
    localparam int unsigned S1 = g / 2;
    localparam int unsigned S0 = g % 2;

    map_acs #(.W_M(W_M)) u_alpha (
      .m0       (alpha_q[S1]),
      .g0       (gin[S1][S0]),
      .m1       (alpha_q[S1 + 2]),
      .g1       (gin[S1][S0]),
      .metric_c (acs_a[g])
    );

    map_acs #(.W_M(W_M)) u_beta (
      .m0       (beta_q[2 * S0]),
      .g0       (gbw[S0][0]),
      .m1       (beta_q[2 * S0 + 1]),
      .g1       (gbw[S0][1]),
      .metric_c (acs_b[g])
    );
  end

  // Normalise so state 0 of the new metric vector sits at zero.
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      alpha_n[s] = W_M'(sat_add(int'(acs_a[s]), -int'(acs_a[0]), LIM));
      beta_n[s]  = W_M'(sat_add(int'(acs_b[s]), -int'(acs_b[0]), LIM));
    end
  end

  // LLR max-trees over the eight branches of step t.
  always_comb begin
    l0 = -LIM;
    l1 = -LIM;
    v  = 0;
    for (int s = 0; s < 4; s++) begin
      for (int u = 0; u < 2; u++) begin
        v = sat_add(sat_add(int'(alpha_buf[t_q][s]), int'(gbw[s % 2][u]), LIM),
                    int'(beta_q[next_state(1'(s), 1'(u))]), LIM);
        if (u == 1) begin
          if (v > l1) l1 = v;
        end else if (v > l0) begin
          l0 = v;
        end
      end
    end
    llr_c = (W_M + 1)'(sat_add(l1, -l0, metric_lim(W_M + 1)));
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      FWD:     if (in_fire_c && (t_q == T_LAST)) fsm_d = BWD;
      BWD:     if (out_fire_c && out_last) fsm_d = FWD;
      default: fsm_d = FWD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= FWD;
    else        fsm_q <= fsm_d;
  end

  // Symbol and alpha history; contents are only meaningful within a block.
  always_ff @(posedge clk) begin
    if (in_fire_c) begin
      ys_buf[t_q]    <= in_ys;
      yp_buf[t_q]    <= in_yp;
      alpha_buf[t_q] <= alpha_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alpha_q   <= '{W_M'(0), NEG_M, NEG_M, NEG_M};
      beta_q    <= '{W_M'(0), W_M'(0), W_M'(0), W_M'(0)};
      t_q       <= '0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_llr   <= '0;
      out_bit   <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      in_ready <= (fsm_d == FWD);

      if (in_fire_c) begin
        if (t_q == T_LAST) begin
          alpha_q <= '{W_M'(0), NEG_M, NEG_M, NEG_M};
          load_q  <= 1'b1;
        end else begin
          alpha_q <= alpha_n;
          t_q     <= t_q + TW'(1);
        end
      end

      if ((fsm_q == BWD) && load_q) begin
        beta_q <= '{W_M'(0), BETA_TAIL, BETA_TAIL, BETA_TAIL};
        load_q <= 1'b0;
      end

      if (step_c) begin
        out_valid <= 1'b1;
        out_llr   <= llr_c;
        out_bit   <= ~llr_c[W_M];
        out_idx   <= t_q;
        out_last  <= (t_q == '0);
        beta_q    <= beta_n;
        if (t_q == '0) done_q <= 1'b1;
        else           t_q    <= t_q - TW'(1);
      end else if (out_fire_c) begin
        out_valid <= 1'b0;
      end

      if (out_fire_c && out_last) begin
        done_q <= 1'b0;
        t_q    <= '0;
      end
    end
  end

endmodule
